// File: rtl/line_clear_ctrl.sv
// Full-row removal engine for a falling-block game board: captures a locked
// board, scans bottom to top, drops everything above each full row, then writes back.
module line_clear_ctrl #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] board_out,
    output logic                 board_we,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           lines_cleared,
    output logic [15:0]          total_lines
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        WRITE
    } state_t;

    state_t               state_reg, state_next;
    logic [RW-1:0]        r_reg, r_next, r_plus;
    logic [4:0]           lines_reg, lines_next;
    logic [15:0]          total_reg;
    logic [16:0]          total_sum;
    logic [ROWS*COLS-1:0] board_out_reg;
    logic                 we_reg;
    logic                 busy_reg;

    logic [COLS-1:0]      board_reg    [ROWS];
    logic [COLS-1:0]      board_next   [ROWS];
    logic [COLS-1:0]      shifted_row  [ROWS];
    logic [ROWS*COLS-1:0] board_next_flat;
    logic [COLS-1:0]      row_above;
    logic                 row_full;
    logic                 row_above_full;
    logic                 capture;
    logic                 do_shift;

    assign capture  = (state_reg == IDLE) && start;
    assign do_shift = (state_reg == SHIFT);

    // Per-row next value: load on capture, drop by one row at and above r on a shift.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            if (gi < ROWS - 1) begin : g_mid
                assign shifted_row[gi] = board_reg[gi+1];
            end else begin : g_top
                assign shifted_row[gi] = '0;
            end
            assign board_next[gi] = capture ? board_in[gi*COLS +: COLS] :
                                    (do_shift && (RW'(gi) >= r_reg)) ? shifted_row[gi] :
                                    board_reg[gi];
            assign board_next_flat[gi*COLS +: COLS] = board_next[gi];
        end
    endgenerate

    // After a shift, row r holds what was row r+1; SHIFT judges that row itself
    // so every removed line costs exactly one extra cycle.
    assign r_plus         = r_reg + RW'(1);
    assign row_above      = (r_reg == LAST_ROW) ? '0 : board_reg[r_plus];
    assign row_full       = &board_reg[r_reg];
    assign row_above_full = &row_above;

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        lines_next = lines_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    r_next     = '0;
                    lines_next = '0;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_next = SHIFT;
                end else if (r_reg == LAST_ROW) begin
                    state_next = WRITE;
                end else begin
                    r_next = r_plus;
                end
            end
            SHIFT: begin
                lines_next = lines_reg + 5'd1;
                if (row_above_full) begin
                    state_next = SHIFT;
                end else if (r_reg == LAST_ROW) begin
                    state_next = WRITE;
                end else begin
                    state_next = SCAN;
                    r_next     = r_plus;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign total_sum = {1'b0, total_reg} + {12'd0, lines_next};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            r_reg         <= '0;
            lines_reg     <= '0;
            total_reg     <= '0;
            board_out_reg <= '0;
            we_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                board_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            lines_reg <= lines_next;
            board_reg <= board_next;
            busy_reg  <= (state_next != IDLE);
            we_reg    <= (state_next == WRITE);
            // Outputs are loaded on the edge entering WRITE so they are valid during it.
            if (state_next == WRITE) begin
                board_out_reg <= board_next_flat;
                total_reg     <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
            end
        end
    end

    assign board_out     = board_out_reg;
    assign board_we      = we_reg;
    assign done          = we_reg;
    assign busy          = busy_reg;
    assign lines_cleared = lines_reg;
    assign total_lines   = total_reg;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomised bench for line_clear_ctrl: a compact-the-board reference model
// predicts every output each cycle, with directed literal cases pinning the model.
module tb_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int N    = ROWS * COLS;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] board_in = '0;
    logic [N-1:0] board_out;
    logic         board_we;
    logic         busy;
    logic         done;
    logic [4:0]   lines_cleared;
    logic [15:0]  total_lines;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .start         (start),
        .board_in      (board_in),
        .board_out     (board_out),
        .board_we      (board_we),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines)
    );

    always #5 Clk = ~Clk;

    // Reference: full rows vanish, survivors keep order and settle from row 0 upward.
    function automatic logic [N-1:0] compact_board(input logic [N-1:0] b);
        logic [N-1:0]    o;
        logic [COLS-1:0] row;
        int              k;
        o = '0;
        k = 0;
        for (int r = 0; r < ROWS; r++) begin
            row = b[r*COLS +: COLS];
            if (row != {COLS{1'b1}}) begin
                o[k*COLS +: COLS] = row;
                k++;
            end
        end
        return o;
    endfunction

    function automatic int count_full(input logic [N-1:0] b);
        int c;
        c = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (b[r*COLS +: COLS] == {COLS{1'b1}}) c++;
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input int b);
        int s;
        s = int'(a) + b;
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    function automatic logic [N-1:0] rand_board(input int full_pct);
        logic [N-1:0] b;
        b = '0;
        for (int r = 0; r < ROWS; r++) begin
            if ($urandom_range(99, 0) < full_pct) b[r*COLS +: COLS] = {COLS{1'b1}};
            else b[r*COLS +: COLS] = COLS'($urandom);
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model state: a capture schedules the write 20+L edges later.
    logic         m_busy  = 1'b0;
    logic         m_we    = 1'b0;
    logic [N-1:0] m_out   = '0;
    logic [N-1:0] m_res   = '0;
    logic [4:0]   m_lines = '0;
    logic [15:0]  m_total = '0;
    int           m_L     = 0;
    int           m_left  = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_busy  <= 1'b0;
            m_we    <= 1'b0;
            m_out   <= '0;
            m_lines <= '0;
            m_total <= '0;
            m_left  <= 0;
        end else if (m_we) begin
            m_we   <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_we    <= 1'b1;
                m_out   <= m_res;
                m_lines <= 5'(m_L);
                m_total <= sat_add(m_total, m_L);
            end
        end else if (start) begin
            m_busy  <= 1'b1;
            m_res   <= compact_board(board_in);
            m_L     <= count_full(board_in);
            m_left  <= ROWS + count_full(board_in);
            m_lines <= '0;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("busy", N'(busy), N'(m_busy));
            chk("board_we", N'(board_we), N'(m_we));
            chk("done", N'(done), N'(m_we));
            chk("total_lines", N'(total_lines), N'(m_total));
            chk("board_out", board_out, m_out);
            if (!m_busy || m_we)
                chk("lines_cleared", N'(lines_cleared), N'(m_lines));
            else if (m_left == ROWS + m_L)
                chk("lines_cleared_at_capture", N'(lines_cleared), N'(0));
        end
    end

    task automatic run_op(input string tag, input logic [N-1:0] b, input int pulse_at,
                          input bit lits, input int exp_lat, input logic [N-1:0] exp_out,
                          input int exp_lines, input int exp_total);
        int n;
        bit seen;
        @(negedge Clk);
        board_in = b;
        start    = 1'b1;
        @(negedge Clk);
        start    = 1'b0;
        board_in = rand_board(50);
        n        = 0;
        seen     = 1'b0;
        while (!seen && n < 100) begin
            @(negedge Clk);
            n++;
            seen  = board_we;
            start = (n == pulse_at);
            if (start) board_in = rand_board(30);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: actual no board_we required board_we within 100 cycles", tag);
        end
        chk({tag, "_latency"}, N'(n), N'(exp_lat));
        if (lits) begin
            chk({tag, "_board_out"}, board_out, exp_out);
            chk({tag, "_lines"}, N'(lines_cleared), N'(exp_lines));
            chk({tag, "_total"}, N'(total_lines), N'(exp_total));
        end
        $display("op %s: latency %0d lines %0d total %0d", tag, n, lines_cleared, total_lines);
        @(negedge Clk);
        start = 1'b0;
    endtask

    initial begin
        logic [N-1:0] b, e, two_full;
        bit saw_we;
        int L;

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        cmp_en = 1'b1;
        // Reset takes priority over a coincident start.
        start = 1'b1;
        board_in = rand_board(50);
        @(negedge Clk);
        start = 1'b0;
        Reset = 1'b0;
        chk("reset_busy", N'(busy), N'(0));
        chk("reset_board_out", board_out, '0);
        chk("reset_total", N'(total_lines), N'(0));

        b = '0;
        b[0*COLS +: COLS] = 10'b1111111110;
        b[1*COLS +: COLS] = 10'b0110000100;
        run_op("no_full", b, 0, 1'b1, 20, b, 0, 0);

        b = '0;
        b[0*COLS +: COLS] = 10'h3FF;
        b[1*COLS +: COLS] = 10'b0000000011;
        e = '0;
        e[0*COLS +: COLS] = 10'b0000000011;
        run_op("single", b, 0, 1'b1, 21, e, 1, 1);

        // Reset arriving at edge +7 aborts without a write.
        two_full = '0;
        two_full[0*COLS +: COLS] = 10'h3FF;
        two_full[1*COLS +: COLS] = 10'b0101010101;
        two_full[2*COLS +: COLS] = 10'h3FF;
        two_full[3*COLS +: COLS] = 10'b0000000111;
        @(negedge Clk);
        board_in = two_full;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        saw_we = 1'b0;
        repeat (6) begin
            @(negedge Clk);
            if (board_we) saw_we = 1'b1;
        end
        Reset = 1'b1;
        @(negedge Clk);
        if (board_we) saw_we = 1'b1;
        Reset = 1'b0;
        chk("abort_no_we", N'(saw_we), N'(0));
        chk("abort_busy", N'(busy), N'(0));
        chk("abort_done", N'(done), N'(0));
        chk("abort_lines", N'(lines_cleared), N'(0));
        chk("abort_total", N'(total_lines), N'(0));
        chk("abort_board_out", board_out, '0);

        b = '0;
        for (int r = 0; r < 4; r++) b[r*COLS +: COLS] = 10'h3FF;
        b[4*COLS +: COLS] = 10'b1000000001;
        b[5*COLS +: COLS] = 10'h3FF;
        b[6*COLS +: COLS] = 10'b0000010000;
        e = '0;
        e[0*COLS +: COLS] = 10'b1000000001;
        e[1*COLS +: COLS] = 10'b0000010000;
        run_op("tetris_gap", b, 0, 1'b1, 25, e, 5, 5);

        b = '0;
        b[0*COLS +: COLS] = 10'h3FF;
        b[1*COLS +: COLS] = 10'b0000000011;
        e = '0;
        e[0*COLS +: COLS] = 10'b0000000011;
        run_op("single_again", b, 0, 1'b1, 21, e, 1, 6);

        b = '1;
        run_op("all_full", b, 0, 1'b1, 40, '0, 20, 26);

        e = '0;
        e[0*COLS +: COLS] = 10'b0101010101;
        e[1*COLS +: COLS] = 10'b0000000111;
        run_op("busy_start", two_full, 2, 1'b1, 22, e, 2, 28);

        b = '0;
        b[19*COLS +: COLS] = 10'h3FF;
        b[18*COLS +: COLS] = 10'b0011001100;
        e = '0;
        e[18*COLS +: COLS] = 10'b0011001100;
        run_op("top_row", b, 0, 1'b1, 21, e, 1, 29);

        for (int t = 0; t < 40; t++) begin
            b = rand_board(int'($urandom_range(60, 0)));
            L = count_full(b);
            run_op($sformatf("rand%0d", t), b, int'($urandom_range(45, 1)), 1'b0,
                   ROWS + L, '0, 0, 0);
        end

        repeat (2) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
